// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: game sequencer for the maze mini-game.
//
// Owns the game FSM, the player cell index, the accepted-move counter and the countdown timer.
// Each direction request is checked against the maze edges and the open-cell bitmap.
//
// Ports:
//   CLK, RESET            - system clock; synchronous active-high reset
//   up/down/left/right    - debounced direction levels (rising edges act)
//   ctrl                  - debounced start/restart/abort level (rising edge acts)
//   pausesw               - pause switch level
//   maze_state            - cell bitmap, bit i = cell i, 1 = open
//   pos                   - current cell index (row*COLS+col)
//   game_state            - 0=IDLE 1=PLAY 2=PAUSE 3=WIN 4=LOSE
//   time_left             - remaining seconds
//   moves                 - accepted-move count, saturating at 1023
//   solved / failed       - one-cycle pulses on entry to WIN / LOSE
//
// Build option: define MAZE_AUTOREPEAT_EN to repeat a held direction every REPEAT_DIV cycles.

module maze_game_ctrl #(
  parameter int unsigned COLS       = 18,
  parameter int unsigned ROWS       = 11,
  parameter int unsigned START_POS  = 19,
  parameter int unsigned GOAL_POS   = 178,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned TIME_LIMIT = 99,
  parameter int unsigned REPEAT_DIV = 25000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  input  logic                 ctrl,
  input  logic                 pausesw,
  input  logic [ROWS*COLS-1:0] maze_state,
  output logic [7:0]           pos,
  output logic [2:0]           game_state,
  output logic [6:0]           time_left,
  output logic [9:0]           moves,
  output logic                 solved,
  output logic                 failed
);

  localparam logic [7:0]  ColsP    = 8'(COLS);
  localparam logic [7:0]  LastCol  = 8'(COLS - 1);
  localparam logic [7:0]  LastRow  = 8'((ROWS - 1) * COLS);
  localparam logic [7:0]  StartP   = 8'(START_POS);
  localparam logic [7:0]  StartCol = 8'(START_POS % COLS);
  localparam logic [7:0]  GoalP    = 8'(GOAL_POS);
  localparam logic [31:0] TickMax  = 32'(TICK_DIV - 1);
  localparam logic [6:0]  TimeInit = 7'(TIME_LIMIT);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPlay  = 3'd1,
    StPause = 3'd2,
    StWin   = 3'd3,
    StLose  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pos_q, pos_d;
  logic [7:0]  col_q, col_d;  // column tracked alongside pos to avoid a divider
  logic [9:0]  moves_q, moves_d;
  logic [6:0]  time_q, time_d;
  logic [31:0] presc_q, presc_d;
  logic        solved_q, failed_q;
  logic [3:0]  dir_prev_q;    // {up, down, left, right}
  logic        ctrl_prev_q;
  logic        armed_q;       // low for the first cycle after reset so held buttons make no edge

  logic [3:0]  dir_lvl, dir_edge, move_req;
  logic        ctrl_edge;
  logic [7:0]  cand, cand_col;
  logic        move_ok;
  logic        tick;

  assign dir_lvl   = {up, down, left, right};
  assign dir_edge  = dir_lvl & ~dir_prev_q & {4{armed_q}};
  assign ctrl_edge = ctrl & ~ctrl_prev_q & armed_q;
  assign tick      = (presc_q == TickMax);

`ifdef MAZE_AUTOREPEAT_EN
  localparam logic [31:0] RepMax = 32'(REPEAT_DIV - 1);

  logic [31:0] rep_cnt_q;
  logic [3:0]  rep_dir_q;  // direction pattern armed by an edge in PLAY; 0 = nothing armed
  logic        rep_fire;

  assign rep_fire = (state_q == StPlay) && (rep_dir_q != 4'd0) && (dir_lvl == rep_dir_q) &&
                    (rep_cnt_q == RepMax);
  assign move_req = dir_edge | (rep_fire ? dir_lvl : 4'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rep_cnt_q <= '0;
      rep_dir_q <= '0;
    end else if (state_q == StPlay && dir_edge != 4'd0) begin
      rep_cnt_q <= '0;
      rep_dir_q <= dir_lvl;
    end else if (state_q != StPlay || dir_lvl != rep_dir_q) begin
      rep_cnt_q <= '0;
      rep_dir_q <= '0;
    end else if (rep_dir_q != 4'd0) begin
      rep_cnt_q <= (rep_cnt_q == RepMax) ? 32'd0 : rep_cnt_q + 32'd1;
    end
  end
`else
  assign move_req = dir_edge;

  // REPEAT_DIV only has meaning in the auto-repeat build.
  if (REPEAT_DIV == 0) begin : g_repeat_div_unused
  end
`endif

  // Candidate cell and legality; priority up > down > left > right.
  always_comb begin
    cand     = pos_q;
    cand_col = col_q;
    move_ok  = 1'b0;
    if (move_req[3]) begin
      cand    = pos_q - ColsP;
      move_ok = (pos_q >= ColsP);
    end else if (move_req[2]) begin
      cand    = pos_q + ColsP;
      move_ok = (pos_q < LastRow);
    end else if (move_req[1]) begin
      cand     = pos_q - 8'd1;
      cand_col = col_q - 8'd1;
      move_ok  = (col_q != 8'd0);
    end else if (move_req[0]) begin
      cand     = pos_q + 8'd1;
      cand_col = col_q + 8'd1;
      move_ok  = (col_q != LastCol);
    end
    if (move_ok && !maze_state[cand]) begin
      move_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    col_d   = col_q;
    moves_d = moves_q;
    time_d  = time_q;
    presc_d = presc_q;
    case (state_q)
      StIdle: begin
        if (ctrl_edge) begin
          state_d = StPlay;
          pos_d   = StartP;
          col_d   = StartCol;
          moves_d = '0;
          time_d  = TimeInit;
          presc_d = '0;
        end
      end
      StPlay: begin
        if (ctrl_edge) begin
          state_d = StIdle;
        end else if (pos_q == GoalP) begin
          state_d = StWin;
        end else if (pausesw) begin
          state_d = StPause;
        end else begin
          if (move_ok) begin
            pos_d = cand;
            col_d = cand_col;
            if (moves_q != 10'd1023) begin
              moves_d = moves_q + 10'd1;
            end
          end
          presc_d = tick ? 32'd0 : presc_q + 32'd1;
          if (tick && time_q != 7'd0) begin
            time_d = time_q - 7'd1;
            // A goal move landing on the expiring tick still wins next cycle.
            if (time_q == 7'd1 && !(move_ok && cand == GoalP)) begin
              state_d = StLose;
            end
          end
        end
      end
      StPause: begin
        if (ctrl_edge) begin
          state_d = StIdle;
        end else if (!pausesw) begin
          state_d = StPlay;
        end
      end
      StWin, StLose: begin
        if (ctrl_edge) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      pos_q       <= StartP;
      col_q       <= StartCol;
      moves_q     <= '0;
      time_q      <= TimeInit;
      presc_q     <= '0;
      solved_q    <= 1'b0;
      failed_q    <= 1'b0;
      dir_prev_q  <= '0;
      ctrl_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      col_q       <= col_d;
      moves_q     <= moves_d;
      time_q      <= time_d;
      presc_q     <= presc_d;
      solved_q    <= (state_d == StWin) && (state_q != StWin);
      failed_q    <= (state_d == StLose) && (state_q != StLose);
      dir_prev_q  <= dir_lvl;
      ctrl_prev_q <= ctrl;
      armed_q     <= 1'b1;
    end
  end

  assign pos        = pos_q;
  assign game_state = state_q;
  assign time_left  = time_q;
  assign moves      = moves_q;
  assign solved     = solved_q;
  assign failed     = failed_q;

endmodule

// File: doc/maze_game_ctrl.md
Name: maze_game_ctrl

Overview:
- Sequencer for the maze mini-game: owns the game state machine, the player position index, the move counter and the countdown timer.
- Validates each requested move against the 198-bit maze bitmap (11 rows x 18 cols, 1 = open cell) and reports win/lose to the top level.
- Sits between the debounced push-buttons and the renderers, which consume pos/game_state.

Parameters:
- COLS, 18, maze width in cells
- ROWS, 11, maze height in cells
- START_POS, 19, cell index loaded on game start (row*COLS+col)
- GOAL_POS, 178, cell index that ends the game as a win
- TICK_DIV, 100000000, CLK cycles per timer second
- TIME_LIMIT, 99, seconds allowed per game (max 127)
- REPEAT_DIV, 25000000, CLK cycles between auto-repeat moves (optional feature only)

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high; all state returns to IDLE values on the next CLK edge
- up, down, left, right  in  1 each  debounced direction levels
- ctrl  in  1  debounced start/restart level
- pausesw  in  1  pause switch level
- maze_state  in  198  cell bitmap; bit i = cell i, 1 = open
- pos  out  8  current cell index
- game_state  out  3  0=IDLE 1=PLAY 2=PAUSE 3=WIN 4=LOSE
- time_left  out  7  remaining seconds
- moves  out  10  accepted-move count, saturates at 1023
- solved  out  1  one-cycle pulse on entry to WIN
- failed  out  1  one-cycle pulse on entry to LOSE

Behaviour:
- Reset values: pos=START_POS, game_state=IDLE, time_left=TIME_LIMIT, moves=0, solved=0, failed=0, prescaler=0, edge registers=0.
- All button inputs are rising-edge detected internally (registered previous level); only edges act.
- IDLE: ctrl edge -> PLAY; the same edge loads pos=START_POS, moves=0, time_left=TIME_LIMIT, prescaler=0.
- PLAY:
  - pausesw=1 -> PAUSE.
  - Direction edge -> candidate cell: up = pos-COLS, down = pos+COLS, left = pos-1, right = pos+1.
  - Move is blocked if row=0 (up), row=ROWS-1 (down), col=0 (left) or col=COLS-1 (right); no wrap-around.
  - Move is also blocked if maze_state[candidate]=0.
  - A legal move updates pos on the edge after the detected rising edge (1-cycle latency) and increments moves.
  - Simultaneous edges: priority up > down > left > right; at most one move per cycle.
  - Entering GOAL_POS -> WIN on the cycle after pos updates; solved pulses for one cycle.
- Timer (PLAY only):
  - prescaler counts 0..TICK_DIV-1.
  - On wrap, time_left decrements.
  - If time_left reaches 0 and pos != GOAL_POS -> LOSE; failed pulses for one cycle.
  - If a goal move and a timeout occur in the same cycle, WIN takes precedence.
- PAUSE: prescaler and time_left frozen; direction edges ignored (not queued); pausesw=0 -> PLAY, resuming from the frozen prescaler value.
- WIN/LOSE: pos, moves and time_left held; ctrl edge -> IDLE.
- ctrl edge in PLAY or PAUSE: abort to IDLE.
- RESET asserted mid-game: forces IDLE regardless of state; a button held through reset does not produce an edge when reset releases.
- maze_state is sampled combinationally at move evaluation; changes while paused take effect on the next move.

Optional Feature:
- MAZE_AUTOREPEAT_EN defined:
  - In PLAY, a direction held continuously after its edge generates an additional move attempt every REPEAT_DIV cycles.
  - The repeat counter clears on release, on a direction change and on leaving PLAY.
  - Repeats obey the same legality and priority rules.
- MAZE_AUTOREPEAT_EN undefined: only rising edges move; REPEAT_DIV unused, no repeat logic synthesised.

Test Plan (TICK_DIV=4, TIME_LIMIT=3, maze with open path 19->20->38 and goal 38):
- RESET, then ctrl pulse -> game_state=1, pos=19, moves=0, time_left=3 one cycle after the edge.
- right edge, then down edge -> pos=20, then pos=38; moves=2; WIN (3) one cycle later; solved high exactly one cycle.
- left edge at pos=19 with cell 18 closed -> pos stays 19, moves=0.
- Start at pos 18 (col 0 edge case): left edge -> blocked, pos unchanged even if maze_state[17]=1.
- Idle in PLAY -> time_left 3->2->1->0 every 4 cycles; LOSE on reaching 0; failed pulses once; ctrl edge -> IDLE.
- pausesw=1 for 20 cycles -> time_left frozen and a right edge is ignored; release -> countdown resumes from the same prescaler value.
- up+right edges in the same cycle at pos=20 with cell 2 closed -> up wins priority and is blocked; right is not taken; pos=20.
- RESET asserted mid-PLAY with right held -> IDLE, pos=19, no move after RESET drops.
